// File: rtl/button_conditioner.sv
// button_conditioner: two-flop sync, per-button debounce FSM, press/release pulses.
// Optional auto-repeat on REPEAT_MASK buttons when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 12_500_000,
   parameter logic [4:0]  REPEAT_MASK     = 5'b00110
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] btn_in,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic [4:0] btn_release,
   output logic       any_press
);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
   localparam logic [31:0] DB = 32'(DEBOUNCE_CYCLES);
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [31:0] RD = 32'(REPEAT_DELAY);
   localparam logic [31:0] RP = 32'(REPEAT_PERIOD);
`endif
   logic [4:0] sync1, sync2, press_nxt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         any_press <= 1'b0;
      end else begin
         sync1     <= btn_in;
         sync2     <= sync1;
         any_press <= |press_nxt;
      end
   genvar b;
   for (b = 0; b < 5; b++) begin : g_btn
      state_t      state;
      logic [31:0] db_cnt, db_inc;
      logic        s, hi, done, accept, lvl, prs, rel;
      assign s      = sync2[b];
      assign hi     = state == HELD || state == RELEASE_WAIT;
      assign db_inc = &db_cnt ? db_cnt : db_cnt + 32'd1;
      assign done   = db_inc >= DB;
      assign accept = !hi && s && done;
      assign btn_level[b]   = lvl;
      assign btn_press[b]   = prs;
      assign btn_release[b] = rel;
`ifdef BUTTON_AUTO_REPEAT_EN
      logic [31:0] rep_cnt, rep_inc;
      logic        rep_first, rep_hit;
      assign rep_inc = rep_cnt + 32'd1;
      // no repeat on the edge that leaves the held side
      assign rep_hit = REPEAT_MASK[b] && hi && !(!s && done) && rep_inc == (rep_first ? RD : RP);
      assign press_nxt[b] = accept | rep_hit;
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else if (accept || rep_hit) begin
            rep_cnt   <= '0;
            rep_first <= accept;
         end else begin
            rep_cnt   <= (hi && REPEAT_MASK[b]) ? rep_inc : '0;
         end
`else
      assign press_nxt[b] = accept;
`endif
      // matching level resets the count; opposite level counts toward a flip
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            state  <= IDLE;
            db_cnt <= '0;
            lvl    <= 1'b0;
            prs    <= 1'b0;
            rel    <= 1'b0;
         end else begin
            prs <= press_nxt[b];
            rel <= hi && !s && done;
            if (hi ? s : !s) begin
               state  <= hi ? HELD : IDLE;
               db_cnt <= '0;
            end else if (done) begin
               state  <= hi ? IDLE : HELD;
               db_cnt <= '0;
               lvl    <= !hi;
            end else begin
               state  <= hi ? RELEASE_WAIT : PRESS_WAIT;
               db_cnt <= db_inc;
            end
         end
   end
endmodule
